// File: rtl/lfu_comparador.sv
// ---------------------------------------------------------------------------
// lfu_comparador
//
// Picks the least frequently used way of a 4-way cache set as the victim.
// The four usage counts are compared as unsigned values in a small pairwise
// tournament: way0 vs way1, way2 vs way3, then the two winners. The result
// is registered, so cache_sel reflects the counts sampled at the previous
// rising edge of clk.
//
// Ports:
//   clk        - sole clock, rising-edge active
//   rst_n      - asynchronous active-low reset; forces cache_sel to way 0
//   count0..3  - WIDTH-bit unsigned usage counts for ways 0..3
//   cache_sel  - one-hot victim select, bit i selects way i
// ---------------------------------------------------------------------------
module lfu_comparador #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] count0,
    input  logic [WIDTH-1:0] count1,
    input  logic [WIDTH-1:0] count2,
    input  logic [WIDTH-1:0] count3,
    output logic [3:0]       cache_sel
);

    logic [WIDTH-1:0] w_min01;
    logic [WIDTH-1:0] w_min23;
    logic             w_pick1;
    logic             w_pick3;
    logic             w_pickRight;
    logic [3:0]       w_nextSel;
    logic [3:0]       r_cacheSel;

    // Tournament. In every match the right-hand side wins only when it is
    // strictly smaller, which is what gives lower-indexed ways priority on
    // ties. The one-hot select is built from the match results, so it can
    // never be zero or multi-hot.
    always_comb begin
        w_pick1     = 1'b0;
        w_pick3     = 1'b0;
        w_pickRight = 1'b0;
        w_min01     = count0;
        w_min23     = count2;
        w_nextSel   = 4'b0001;

        w_pick1 = (count1 < count0);
        w_pick3 = (count3 < count2);
        w_min01 = w_pick1 ? count1 : count0;
        w_min23 = w_pick3 ? count3 : count2;
        w_pickRight = (w_min23 < w_min01);

        case ({w_pickRight, w_pickRight ? w_pick3 : w_pick1})
            2'b00:   w_nextSel = 4'b0001;
            2'b01:   w_nextSel = 4'b0010;
            2'b10:   w_nextSel = 4'b0100;
            default: w_nextSel = 4'b1000;
        endcase
    end

    // Output register; reset parks the select on way 0 immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cacheSel <= 4'b0001;
        end else begin
            r_cacheSel <= w_nextSel;
        end
    end

    assign cache_sel = r_cacheSel;

endmodule

// File: tb/tb_lfu_comparador.sv
// ---------------------------------------------------------------------------
// tb_lfu_comparador
//
// Self-checking bench for lfu_comparador. Counts are driven on the falling
// edge, the expected select (lowest-index minimum) is pushed to a queue at
// the same time, and popped and compared just after the following rising
// edge.
// ---------------------------------------------------------------------------
module tb_lfu_comparador;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] count0;
    logic [WIDTH-1:0] count1;
    logic [WIDTH-1:0] count2;
    logic [WIDTH-1:0] count3;
    logic [3:0]       cache_sel;

    logic [3:0] expQ[$];
    int passCount;
    int totalCount;

    lfu_comparador #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .count0    (count0),
        .count1    (count1),
        .count2    (count2),
        .count3    (count3),
        .cache_sel (cache_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: scan ways in order, replace only on strictly smaller.
    function automatic logic [3:0] modelSel(input logic [WIDTH-1:0] c0,
                                            input logic [WIDTH-1:0] c1,
                                            input logic [WIDTH-1:0] c2,
                                            input logic [WIDTH-1:0] c3);
        logic [WIDTH-1:0] vals[4];
        int best;
        logic [3:0] sel;
        vals[0] = c0;
        vals[1] = c1;
        vals[2] = c2;
        vals[3] = c3;
        best = 0;
        for (int i = 1; i < 4; i++) begin
            if (vals[i] < vals[best]) best = i;
        end
        sel = 4'b0000;
        sel[best] = 1'b1;
        return sel;
    endfunction

    task automatic compareNow(input string tag, input logic [3:0] expected);
        totalCount++;
        assert (cache_sel === expected) passCount++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, cache_sel, expected);
    endtask

    // Drive one count vector on the falling edge and queue its expected select.
    task automatic applyStimulus(input logic [WIDTH-1:0] c0,
                                 input logic [WIDTH-1:0] c1,
                                 input logic [WIDTH-1:0] c2,
                                 input logic [WIDTH-1:0] c3);
        @(negedge clk);
        count0 = c0;
        count1 = c1;
        count2 = c2;
        count3 = c3;
        expQ.push_back(modelSel(c0, c1, c2, c3));
    endtask

    // Compare the DUT output just after the next rising edge against the queue.
    task automatic checkOutput(input string tag);
        logic [3:0] expected;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            totalCount++;
            $error("[TB] FAIL %s: observed %b expected <empty scoreboard>", tag, cache_sel);
        end else begin
            expected = expQ.pop_front();
            compareNow(tag, expected);
        end
    endtask

    initial begin
        logic [3:0] oneHot;
        passCount  = 0;
        totalCount = 0;
        rst_n  = 1'b1;
        count0 = 4'd3;
        count1 = 4'd2;
        count2 = 4'd1;
        count3 = 4'd0;

        // Asynchronous reset between edges, held across an edge, then released.
        #2 rst_n = 1'b0;
        #1 compareNow("resetAsync", 4'b0001);
        @(posedge clk);
        #1 compareNow("resetHold", 4'b0001);
        applyStimulus(4'd3, 4'd2, 4'd1, 4'd0);
        rst_n = 1'b1;
        checkOutput("resetRelease");

        // Directed vectors, including ties and unsigned extremes.
        applyStimulus(4'd0, 4'd0, 4'd0, 4'd0);    checkOutput("allZero");
        applyStimulus(4'd7, 4'd7, 4'd7, 4'd7);    checkOutput("allSeven");
        applyStimulus(4'd15, 4'd15, 4'd15, 4'd15); checkOutput("allMax");
        applyStimulus(4'd0, 4'd0, 4'd0, 4'd2);    checkOutput("tie001");
        applyStimulus(4'd0, 4'd3, 4'd3, 4'd0);    checkOutput("tie0330");
        applyStimulus(4'd4, 4'd2, 4'd3, 4'd4);    checkOutput("v4234");
        applyStimulus(4'd9, 4'd1, 4'd2, 4'd3);    checkOutput("v9123");
        applyStimulus(4'd0, 4'd10, 4'd2, 4'd3);   checkOutput("v0_10_2_3");
        applyStimulus(4'd5, 4'd5, 4'd1, 4'd1);    checkOutput("tie5511");
        applyStimulus(4'd15, 4'd15, 4'd15, 4'd14); checkOutput("maxBoundary");
        applyStimulus(4'd8, 4'd9, 4'd7, 4'd8);    checkOutput("way2Wins");

        // Latency: a mid-cycle input change must not reach the output early.
        applyStimulus(4'd0, 4'd1, 4'd2, 4'd3);    checkOutput("latencyBase");
        applyStimulus(4'd4, 4'd2, 4'd3, 4'd1);
        #1 compareNow("latencyHold", 4'b0001);
        checkOutput("latencyUpdate");

        // Reset mid-operation discards the pending result.
        applyStimulus(4'd6, 4'd5, 4'd0, 4'd4);
        #2 rst_n = 1'b0;
        expQ.delete();
        #1 compareNow("midReset", 4'b0001);
        @(posedge clk);
        #1 compareNow("midResetHold", 4'b0001);
        applyStimulus(4'd5, 4'd5, 4'd1, 4'd1);
        rst_n = 1'b1;
        checkOutput("midResetRelease");

        // Random vectors: one-hot every cycle and matching the model.
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)),
                          WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)));
            checkOutput("random");
            oneHot = ($countones(cache_sel) == 1) ? cache_sel : 4'b0000;
            compareNow("randomOneHot", oneHot);
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/lfu_comparador.md
LFU_COMPARADOR -- requirements
Module: lfu_comparador

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of each usage counter input; legal range WIDTH >= 1.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: count0  input  WIDTH  usage count of cache way 0, unsigned.
REQ-005 Port: count1  input  WIDTH  usage count of cache way 1, unsigned.
REQ-006 Port: count2  input  WIDTH  usage count of cache way 2, unsigned.
REQ-007 Port: count3  input  WIDTH  usage count of cache way 3, unsigned.
REQ-008 Port: cache_sel  output  4  one-hot victim select; bit i set selects way i.
REQ-009 Port order SHALL be clk, rst_n, count0, count1, count2, count3, cache_sel.

Function
REQ-010 The block SHALL select the way with the smallest count (least frequently used) as victim.
REQ-011 Counts SHALL be compared as unsigned WIDTH-bit values, with no sign extension and no saturation.
REQ-012 On ties for the minimum, the lowest-indexed tied way SHALL win (way0 > way1 > way2 > way3 priority).
REQ-013 All four counts equal (including all zero or all max) SHALL yield cache_sel = 4'b0001.
REQ-014 cache_sel SHALL be a register: one-clock latency from inputs sampled at a rising edge to the updated output.
REQ-015 cache_sel SHALL always be exactly one-hot; 4'b0000 and multi-hot values are illegal at all times.
REQ-016 The comparison SHALL be a pairwise tournament, (0 vs 1), (2 vs 3), then winners; each compare is "right wins only if strictly smaller".
REQ-017 Inputs SHALL be sampled every cycle; there is no enable or handshake, and the output tracks inputs with 1-cycle delay.
REQ-018 Input changes between clock edges SHALL NOT affect cache_sel until the next rising edge.

Reset
REQ-019 While rst_n = 0, cache_sel SHALL be 4'b0001 (way 0), asserted asynchronously without waiting for clk.
REQ-020 Reset asserted mid-operation SHALL force cache_sel to 4'b0001 immediately and discard the pending comparison.
REQ-021 After rst_n deasserts, the first rising edge SHALL load the comparison result of the inputs present at that edge.

Verification
REQ-022 rst_n=0 with counts {3,2,1,0} -> cache_sel=4'b0001 immediately; release rst_n, one edge later -> 4'b1000.
REQ-023 counts {0,0,0,0} -> 4'b0001; counts {7,7,7,7} -> 4'b0001; counts {0,0,0,2} -> 4'b0001 (tie priority).
REQ-024 counts {0,3,3,0} -> 4'b0001; counts {4,2,3,4} -> 4'b0010; counts {9,1,2,3} -> 4'b0010; counts {0,10,2,3} -> 4'b0001.
REQ-025 counts {5,5,1,1} -> 4'b0100; counts {15,15,15,14} -> 4'b1000 (max-value unsigned boundary).
REQ-026 Latency check: change counts from {0,1,2,3} to {4,2,3,1} between edges -> cache_sel stays 4'b0001 until the next rising edge, then 4'b1000.
REQ-027 Random check: 1000 random count vectors -> cache_sel one-hot every cycle and equal to the lowest-index minimum of the prior cycle's inputs.
